data_mem_ctrl: RTL and testbench

Parametrised byte-addressable data memory for the CPU load/store path, replacing the fixed 85-word, word-indexed, combinational-read memory. Accepts one load or store per handshake with byte, halfword or word size, performs byte-lane stores and sign/zero-extended loads, and reports misaligned and out-of-range accesses. Read latency is configurable, and a response is returned for every accepted request.

---
 rtl/data_mem_if.sv | 26 ++
 rtl/data_mem_ctrl.sv | 169 ++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_if.sv
// Request/response bus between a load/store unit and the data memory
// controller. One request per handshake, one response pulse per request.
interface data_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;

    // Load/store unit side.
    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    // Memory controller side.
    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Byte-addressable data memory with byte/halfword/word stores and
// sign/zero-extended loads. Stores commit on the accept edge, loads sample
// the addressed word on the accept edge, and the response is returned after
// LATENCY cycles. Misaligned/illegal-size and out-of-range accesses are
// flagged and have no effect on memory.
module data_mem_ctrl #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 1     // 1..4
) (
    input  logic       clk,
    input  logic       rst,
    data_mem_if.slave  bus
);

    localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [1:0] CNT_INIT = 2'(LATENCY - 1);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  count_q, count_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic             accept;
    logic             misaligned;
    logic             out_of_range;
    logic [IDX_W-1:0] idx;
    logic [31:0]      word_rd;
    logic [7:0]       byte_val;
    logic [15:0]      half_val;
    logic [31:0]      load_data;
    logic [31:0]      wr_mask;
    logic [31:0]      wr_data;

    logic [31:0] rdata_q;
    logic [1:0]  err_q;

    // req_ready depends on state only, so there is no path from req_valid.
    assign bus.req_ready = (state_q != S_WAIT);
    assign accept        = bus.req_valid && bus.req_ready;

    assign idx          = bus.req_addr[IDX_W+1:2];
    assign out_of_range = ({2'b00, bus.req_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign word_rd      = mem[idx];

    // Classify alignment of the request against its size.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        misaligned = 1'b0;
        case (bus.req_size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = bus.req_addr[0];
            SZ_WORD: misaligned = (bus.req_addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // Select the addressed lane of the word and extend it for loads.
    always_comb begin
        byte_val  = 8'(word_rd >> {bus.req_addr[1:0], 3'b000});
        half_val  = 16'(word_rd >> {bus.req_addr[1], 4'b0000});
        load_data = word_rd;
        case (bus.req_size)
            SZ_BYTE: load_data = bus.req_unsigned ? {24'h0, byte_val}
                                                  : {{24{byte_val[7]}}, byte_val};
            SZ_HALF: load_data = bus.req_unsigned ? {16'h0, half_val}
                                                  : {{16{half_val[15]}}, half_val};
            default: load_data = word_rd;
        endcase
    end

    // Build the lane mask and replicated data for sub-word stores.
    always_comb begin
        wr_mask = 32'hFFFF_FFFF;
        wr_data = bus.req_wdata;
        case (bus.req_size)
            SZ_BYTE: begin
                wr_mask = 32'h0000_00FF << {bus.req_addr[1:0], 3'b000};
                wr_data = {4{bus.req_wdata[7:0]}};
            end
            SZ_HALF: begin
                wr_mask = 32'h0000_FFFF << {bus.req_addr[1], 4'b0000};
                wr_data = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                wr_mask = 32'hFFFF_FFFF;
                wr_data = bus.req_wdata;
            end
        endcase
    end

    // Commit stores on the accept edge; errored accesses and reset edges write nothing.
    always_ff @(posedge clk) begin
        // NOTE: the memory array has no reset branch; contents survive rst and
        // the array maps onto plain RAM without a per-bit clear.
        if (!rst && accept && bus.req_we && !misaligned && !out_of_range) begin
            mem[idx] <= (word_rd & ~wr_mask) | (wr_data & wr_mask);
        end
    end

    // State and latency counter register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before this edge.
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= 2'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-state logic. WAIT counts down from LATENCY-1 and moves to RESP on
    // the edge where the count reaches 0, so a new request can be accepted
    // every LATENCY cycles.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            S_IDLE, S_RESP: begin
                if (accept) begin
                    state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
                    count_d = CNT_INIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (count_q <= 2'd1) begin
                    state_d = S_RESP;
                    count_d = 2'd0;
                end else begin
                    count_d = count_q - 2'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                count_d = 2'd0;
            end
        endcase
    end

    // Capture response data and error flags at accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= 32'h0;
            err_q   <= 2'b00;
        end else if (accept) begin
            err_q   <= {out_of_range, misaligned};
            rdata_q <= (bus.req_we || misaligned || out_of_range) ? 32'h0 : load_data;
        end
    end

    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_rdata = bus.rsp_valid ? rdata_q : 32'h0;
    assign bus.rsp_err   = bus.rsp_valid ? err_q   : 2'b00;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: one instance with LATENCY=1 and one with
// LATENCY=3, sharing clock and reset.
module tb_data_mem_ctrl;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    logic clk;
    logic rst;

    data_mem_if bus1 ();
    data_mem_if bus3 ();

    data_mem_ctrl #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    data_mem_ctrl #(.DEPTH_WORDS(256), .LATENCY(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one request on the LATENCY=1 instance, leaving req_valid high;
    // returns at the falling edge after the accept edge with the response visible.
    task automatic tx1(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata);
        bus1.req_we       = we;
        bus1.req_addr     = addr;
        bus1.req_size     = size;
        bus1.req_unsigned = uns;
        bus1.req_wdata    = wdata;
        bus1.req_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Full transaction on the LATENCY=3 instance: reports response data,
    // error bits and the number of edges from accept (inclusive) to response.
    task automatic tx3(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic [1:0] err, output int lat);
        check("ready3_pre", 32'(bus3.req_ready), 32'd1);
        bus3.req_we       = we;
        bus3.req_addr     = addr;
        bus3.req_size     = size;
        bus3.req_unsigned = uns;
        bus3.req_wdata    = wdata;
        bus3.req_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus3.req_valid = 1'b0;
        lat = 1;
        while (!bus3.rsp_valid && lat < 10) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        rdata = bus3.rsp_rdata;
        err   = bus3.rsp_err;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  er;
        int          lat;
        int          nrsp;
        int          pulses;
        logic        resp_phase;
        logic [31:0] exp_rd [4];

        bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0;
        bus1.req_size = SZ_W; bus1.req_unsigned = 1'b0; bus1.req_wdata = '0;
        bus3.req_valid = 1'b0; bus3.req_we = 1'b0; bus3.req_addr = '0;
        bus3.req_size = SZ_W; bus3.req_unsigned = 1'b0; bus3.req_wdata = '0;

        // Reset for two cycles, then idle outputs.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_ready1", 32'(bus1.req_ready), 32'd1);
        check("rst_valid1", 32'(bus1.rsp_valid), 32'd0);
        check("rst_rdata1", bus1.rsp_rdata, 32'h0);
        check("rst_err1",   32'(bus1.rsp_err), 32'd0);
        check("rst_ready3", 32'(bus3.req_ready), 32'd1);
        check("rst_valid3", 32'(bus3.rsp_valid), 32'd0);

        // Store/load round trip, back to back.
        tx1(1'b1, 32'h10, SZ_W, 1'b0, 32'hDEAD_BEEF);
        check("sw_valid", 32'(bus1.rsp_valid), 32'd1);
        check("sw_rdata", bus1.rsp_rdata, 32'h0);
        check("sw_err",   32'(bus1.rsp_err), 32'd0);
        tx1(1'b0, 32'h10, SZ_W, 1'b0, 32'h0);
        check("lw_valid", 32'(bus1.rsp_valid), 32'd1);
        check("lw_rdata", bus1.rsp_rdata, 32'hDEAD_BEEF);

        // Byte/halfword lanes and extension.
        tx1(1'b1, 32'h20, SZ_W, 1'b0, 32'h0);
        tx1(1'b1, 32'h21, SZ_B, 1'b0, 32'hAAAA_AA80);
        tx1(1'b0, 32'h21, SZ_B, 1'b0, 32'h0);
        check("lb",  bus1.rsp_rdata, 32'hFFFF_FF80);
        tx1(1'b0, 32'h21, SZ_B, 1'b1, 32'h0);
        check("lbu", bus1.rsp_rdata, 32'h0000_0080);
        tx1(1'b0, 32'h20, SZ_H, 1'b0, 32'h0);
        check("lh",  bus1.rsp_rdata, 32'hFFFF_8000);
        tx1(1'b0, 32'h20, SZ_H, 1'b1, 32'h0);
        check("lhu", bus1.rsp_rdata, 32'h0000_8000);
        tx1(1'b1, 32'h22, SZ_H, 1'b0, 32'h1234_BEEF);
        tx1(1'b0, 32'h20, SZ_W, 1'b1, 32'h0);
        check("sh_word", bus1.rsp_rdata, 32'hBEEF_8000);
        tx1(1'b0, 32'h22, SZ_H, 1'b1, 32'h0);
        check("lhu_hi", bus1.rsp_rdata, 32'h0000_BEEF);
        tx1(1'b0, 32'h23, SZ_B, 1'b0, 32'h0);
        check("lb_hi", bus1.rsp_rdata, 32'hFFFF_FFBE);

        // Error reporting.
        tx1(1'b0, 32'h3, SZ_H, 1'b0, 32'h0);
        check("lh_mis_err",   32'(bus1.rsp_err), 32'd1);
        check("lh_mis_rdata", bus1.rsp_rdata, 32'h0);
        tx1(1'b1, 32'h402, SZ_W, 1'b0, 32'h1111_1111);
        check("sw_oor_err", 32'(bus1.rsp_err), 32'd3);
        tx1(1'b0, 32'h10, SZ_X, 1'b0, 32'h0);
        check("size11_err",   32'(bus1.rsp_err), 32'd1);
        check("size11_rdata", bus1.rsp_rdata, 32'h0);
        tx1(1'b0, 32'h21, SZ_H, 1'b0, 32'h0);
        check("lh_odd_rdata", bus1.rsp_rdata, 32'h0);
        tx1(1'b1, 32'h10, SZ_X, 1'b0, 32'h1234_5678);
        check("ss11_err", 32'(bus1.rsp_err), 32'd1);
        tx1(1'b1, 32'h12, SZ_W, 1'b0, 32'h1234_5678);
        check("sw_mis_err", 32'(bus1.rsp_err), 32'd1);
        tx1(1'b0, 32'h10, SZ_W, 1'b0, 32'h0);
        check("mem_unchanged", bus1.rsp_rdata, 32'hDEAD_BEEF);
        check("mem_unch_err",  32'(bus1.rsp_err), 32'd0);
        tx1(1'b0, 32'h400, SZ_B, 1'b0, 32'h0);
        check("lb_oor_err",   32'(bus1.rsp_err), 32'd2);
        tx1(1'b0, 32'h3FC, SZ_W, 1'b0, 32'h0);
        check("lw_last_err", 32'(bus1.rsp_err), 32'd0);
        bus1.req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("idle_valid1", 32'(bus1.rsp_valid), 32'd0);
        check("idle_rdata1", bus1.rsp_rdata, 32'h0);
        check("idle_err1",   32'(bus1.rsp_err), 32'd0);

        // LATENCY=3: fill four words, first one checks latency.
        for (int i = 0; i < 4; i++) begin
            exp_rd[i] = 32'hA000_0000 + 32'(i * 32'h0101_0101);
            tx3(1'b1, 32'(4 * i), SZ_W, 1'b0, exp_rd[i], rd, er, lat);
            check("l3_sw_lat",   32'(lat), 32'd3);
            check("l3_sw_rdata", rd, 32'h0);
        end

        // Four loads with req_valid held high: one accept every 3 cycles.
        bus3.req_we    = 1'b0;
        bus3.req_size  = SZ_W;
        bus3.req_addr  = 32'h0;
        bus3.req_valid = 1'b1;
        nrsp = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            resp_phase = ((k % 3) == 2);
            check("thr_valid", 32'(bus3.rsp_valid), 32'(resp_phase));
            check("thr_ready", 32'(bus3.req_ready), 32'(resp_phase));
            if (bus3.rsp_valid && nrsp < 4) begin
                check("thr_rdata", bus3.rsp_rdata, exp_rd[nrsp]);
                nrsp++;
            end
            if (resp_phase) begin
                if ((k / 3) + 1 < 4) bus3.req_addr = 32'(4 * ((k / 3) + 1));
                else                 bus3.req_valid = 1'b0;
            end
        end
        check("thr_count", 32'(nrsp), 32'd4);
        @(posedge clk);
        @(negedge clk);

        // Reset one cycle after a store is accepted: no response, store kept.
        bus3.req_we    = 1'b1;
        bus3.req_addr  = 32'h8;
        bus3.req_size  = SZ_W;
        bus3.req_wdata = 32'h0000_0055;
        bus3.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus3.req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_ready", 32'(bus3.req_ready), 32'd1);
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            if (bus3.rsp_valid) pulses++;
            @(posedge clk);
            @(negedge clk);
        end
        check("rst_mid_no_rsp", 32'(pulses), 32'd0);

        // A request presented during rst is not accepted and writes nothing.
        bus3.req_we    = 1'b1;
        bus3.req_addr  = 32'h8;
        bus3.req_wdata = 32'h0000_00AA;
        bus3.req_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus3.req_valid = 1'b0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("rst_req_no_rsp", 32'(bus3.rsp_valid), 32'd0);

        tx3(1'b0, 32'h8, SZ_W, 1'b0, 32'h0, rd, er, lat);
        check("rst_mid_lw",     rd, 32'h0000_0055);
        check("rst_mid_lw_lat", 32'(lat), 32'd3);
        check("rst_mid_lw_err", 32'(er), 32'd0);

        @(posedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
